sirv_plic_icb_arbt: RTL

- 2-to-1 ICB arbiter that shares the single PLIC register-access ICB port between two masters: m0 = core system bus, m1 = debug/secondary master.
- Round-robin command arbitration.
- Grant is held stable while a command is stalled.
- The requester ID of each accepted command is tracked in an in-order outstanding FIFO, so each response is routed back to its originator.
- Sits directly in front of the PLIC slave port; the PLIC returns responses strictly in order.

---
 rtl/sirv_plic_icb_arbt_if.sv | 27 ++
 rtl/sirv_plic_icb_arbt.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sirv_plic_icb_arbt_if.sv
// ICB request/response bundle used between the PLIC arbiter, its two
// upstream masters and the PLIC register slave port.
interface sirv_plic_icb_arbt_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;

    // Side that issues commands and consumes responses
    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    // Side that accepts commands and produces responses
    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );
endinterface

// File: rtl/sirv_plic_icb_arbt.sv
// 2-to-1 round-robin ICB arbiter in front of the PLIC register port.
// m0 = core system bus, m1 = debug/secondary master. Requester IDs of
// accepted commands are kept in an in-order FIFO so responses (which the
// PLIC returns strictly in order) are routed back to their originator.
// Command and response paths are purely combinational.
module sirv_plic_icb_arbt #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sirv_plic_icb_arbt_if.slave    m0_icb,
    sirv_plic_icb_arbt_if.slave    m1_icb,
    sirv_plic_icb_arbt_if.master   s_icb,
    output logic                   rsp_orphan
);

    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(OUTS_DEPTH);
    localparam logic [PW-1:0] C_LAST  = PW'(OUTS_DEPTH - 1);

    // Pointer advance with wrap at OUTS_DEPTH (stays 0 for a 1-deep FIFO)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == C_LAST) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Outstanding-ID FIFO and arbitration state
    logic [OUTS_DEPTH-1:0] r_fifo;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_last_gnt;
    logic                  r_lock;
    logic                  r_locked_id;
    logic                  r_orphan;

    logic w_full;
    logic w_empty;
    logic w_gnt;
    logic w_gnt_valid;
    logic w_s_cmd_valid;
    logic w_cmd_fire;
    logic w_head;
    logic w_s_rsp_ready;
    logic w_rsp_fire;

    assign w_full  = (r_cnt == C_DEPTH);
    assign w_empty = (r_cnt == CW'(0));
    assign w_head  = r_fifo[r_rd_ptr];

    // Grant selection: a stalled command keeps its grant, otherwise round-robin
    always_comb begin
        w_gnt = 1'b0;
        if (r_lock) begin
            w_gnt = r_locked_id;
        end else if (m0_icb.icb_cmd_valid && !m1_icb.icb_cmd_valid) begin
            w_gnt = 1'b0;
        end else if (!m0_icb.icb_cmd_valid && m1_icb.icb_cmd_valid) begin
            w_gnt = 1'b1;
        end else if (m0_icb.icb_cmd_valid && m1_icb.icb_cmd_valid) begin
            w_gnt = ~r_last_gnt;
        end else begin
            w_gnt = 1'b0;
        end
    end

    assign w_gnt_valid   = w_gnt ? m1_icb.icb_cmd_valid : m0_icb.icb_cmd_valid;
    // A full FIFO blocks new commands even if a pop happens in the same cycle
    assign w_s_cmd_valid = rst_n & ~w_full & w_gnt_valid;
    assign w_cmd_fire    = w_s_cmd_valid & s_icb.icb_cmd_ready;

    // Command path: mux the granted master onto the PLIC port
    always_comb begin
        s_icb.icb_cmd_valid = w_s_cmd_valid;
        if (w_gnt) begin
            s_icb.icb_cmd_addr  = m1_icb.icb_cmd_addr;
            s_icb.icb_cmd_read  = m1_icb.icb_cmd_read;
            s_icb.icb_cmd_wdata = m1_icb.icb_cmd_wdata;
        end else begin
            s_icb.icb_cmd_addr  = m0_icb.icb_cmd_addr;
            s_icb.icb_cmd_read  = m0_icb.icb_cmd_read;
            s_icb.icb_cmd_wdata = m0_icb.icb_cmd_wdata;
        end
        m0_icb.icb_cmd_ready = rst_n & ~w_full & s_icb.icb_cmd_ready & ~w_gnt;
        m1_icb.icb_cmd_ready = rst_n & ~w_full & s_icb.icb_cmd_ready &  w_gnt;
    end

    // Response path: route to the FIFO head owner; with nothing outstanding, swallow it
    always_comb begin
        m0_icb.icb_rsp_rdata = s_icb.icb_rsp_rdata;
        m1_icb.icb_rsp_rdata = s_icb.icb_rsp_rdata;
        m0_icb.icb_rsp_valid = rst_n & ~w_empty & ~w_head & s_icb.icb_rsp_valid;
        m1_icb.icb_rsp_valid = rst_n & ~w_empty &  w_head & s_icb.icb_rsp_valid;
        if (!rst_n) begin
            w_s_rsp_ready = 1'b0;
        end else if (w_empty) begin
            w_s_rsp_ready = 1'b1;
        end else if (w_head) begin
            w_s_rsp_ready = m1_icb.icb_rsp_ready;
        end else begin
            w_s_rsp_ready = m0_icb.icb_rsp_ready;
        end
        s_icb.icb_rsp_ready = w_s_rsp_ready;
    end

    assign w_rsp_fire = s_icb.icb_rsp_valid & w_s_rsp_ready & ~w_empty;

    // FIFO push/pop, occupancy, round-robin history, stall lock and orphan flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_last_gnt  <= 1'b1;
            r_lock      <= 1'b0;
            r_locked_id <= 1'b0;
            r_orphan    <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_fifo[r_wr_ptr] <= w_gnt;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
                r_last_gnt       <= w_gnt;
            end
            if (w_rsp_fire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_cmd_fire, w_rsp_fire})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_lock <= w_s_cmd_valid & ~s_icb.icb_cmd_ready;
            if (w_s_cmd_valid && !s_icb.icb_cmd_ready) begin
                r_locked_id <= w_gnt;
            end
            r_orphan <= w_empty & s_icb.icb_rsp_valid;
        end
    end

    assign rsp_orphan = r_orphan;

endmodule
